// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch front end with a DEPTH-entry in-order queue and redirect flush
// Ports: clk, rst (asynchronous, active-low); imem_req_* issue sequential fetch requests;
// imem_rsp_* in-order, never back-pressured responses; redirect_* EX-stage redirect pulse;
// id_* head instruction handed to ID.
// Define FETCH_PERF_EN to add saturating perf_fetched/perf_dropped counters.
module fetch_queue #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_pc,
  output logic [31:0]     id_inst
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_dropped
`endif
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] pc_q [DEPTH];
  logic [XLEN-1:0] pc_d [DEPTH];
  logic [31:0]     inst_q [DEPTH];
  logic [31:0]     inst_d [DEPTH];
  logic [DEPTH-1:0] filled_q, filled_d;
  logic [AW-1:0]   head_q, head_d, alloc_q, alloc_d, fill_q, fill_d;
  logic [CW-1:0]   cnt_q, cnt_d, pend_q, pend_d, drop_cnt_q, drop_cnt_d;
  logic [XLEN-1:0] last_pc_q, last_pc_d;
  logic [31:0]     last_inst_q, last_inst_d;
  logic credit_ok, req_fire, id_fire, head_filled, rsp_drop, rsp_fill;
  logic unused_pc_lsb;
  assign unused_pc_lsb = ^redirect_pc[1:0];
  // credit counts allocated entries plus responses still owed to a flushed stream
  assign credit_ok      = ({1'b0, cnt_q} + {1'b0, drop_cnt_q}) < DEPTH_C;
  assign imem_req_valid = rst && credit_ok && !redirect_valid;
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign head_filled    = filled_q[head_q];
  assign id_valid       = head_filled && !redirect_valid;
  assign id_fire        = id_valid && id_ready;
  // with nothing at the head, keep showing the last presented instruction
  assign id_pc          = head_filled ? pc_q[head_q] : last_pc_q;
  assign id_inst        = head_filled ? inst_q[head_q] : last_inst_q;
  assign rsp_drop       = imem_rsp_valid && (redirect_valid || drop_cnt_q != '0);
  assign rsp_fill       = imem_rsp_valid && !rsp_drop;
  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    pc_d        = pc_q;
    inst_d      = inst_q;
    filled_d    = filled_q;
    head_d      = head_q;
    alloc_d     = alloc_q;
    fill_d      = fill_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    drop_cnt_d  = drop_cnt_q;
    last_pc_d   = id_pc;
    last_inst_d = id_inst;
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
      filled_d   = '0;
      head_d     = '0;
      alloc_d    = '0;
      fill_d     = '0;
      cnt_d      = '0;
      pend_d     = '0;
      // every unfilled entry still has a response on the way; this cycle's one is already gone
      drop_cnt_d = drop_cnt_q + pend_q - CW'(imem_rsp_valid);
    end else begin
      if (id_fire) begin
        filled_d[head_q] = 1'b0;
        head_d           = head_q + AW'(1);
      end
      if (req_fire) begin
        pc_d[alloc_q]     = fetch_pc_q;
        filled_d[alloc_q] = 1'b0;
        alloc_d           = alloc_q + AW'(1);
        fetch_pc_d        = fetch_pc_q + XLEN'(4);
      end
      if (rsp_drop) drop_cnt_d = drop_cnt_q - CW'(1);
      if (rsp_fill) begin
        inst_d[fill_q]   = imem_rsp_data;
        filled_d[fill_q] = 1'b1;
        fill_d           = fill_q + AW'(1);
      end
      cnt_d  = cnt_q + CW'(req_fire) - CW'(id_fire);
      pend_d = pend_q + CW'(req_fire) - CW'(rsp_fill);
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q  <= RESET_PC;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= '0;
        inst_q[i] <= '0;
      end
      filled_q    <= '0;
      head_q      <= '0;
      alloc_q     <= '0;
      fill_q      <= '0;
      cnt_q       <= '0;
      pend_q      <= '0;
      drop_cnt_q  <= '0;
      last_pc_q   <= '0;
      last_inst_q <= '0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      pc_q        <= pc_d;
      inst_q      <= inst_d;
      filled_q    <= filled_d;
      head_q      <= head_d;
      alloc_q     <= alloc_d;
      fill_q      <= fill_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      drop_cnt_q  <= drop_cnt_d;
      last_pc_q   <= last_pc_d;
      last_inst_q <= last_inst_d;
    end
  end
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_fetched_d, perf_dropped_q, perf_dropped_d;
  logic [CW:0] drop_inc;
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [CW:0] b);
    logic [32:0] s;
    s = {1'b0, a} + 33'(b);
    return s[32] ? '1 : s[31:0];
  endfunction
  // flushed filled entries plus discarded words; unfilled entries are counted when their word is dropped
  assign drop_inc       = (redirect_valid ? {1'b0, cnt_q - pend_q} : '0) + (CW+1)'(rsp_drop);
  assign perf_fetched_d = sat_add(perf_fetched_q, (CW+1)'(id_fire));
  assign perf_dropped_d = sat_add(perf_dropped_q, drop_inc);
  assign perf_fetched   = perf_fetched_q;
  assign perf_dropped   = perf_dropped_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetched_q <= '0;
      perf_dropped_q <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_dropped_q <= perf_dropped_d;
    end
  end
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: table, directed and random checks of fetch_queue against an in-order imem and PC-stream model
module tb_fetch_queue;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst;
  logic imem_req_valid, imem_req_ready, imem_rsp_valid, redirect_valid, id_valid, id_ready;
  logic [31:0] imem_req_addr, imem_rsp_data, redirect_pc, id_pc, id_inst;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_dropped;
`endif
  always #5 clk = ~clk;
  fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC('0)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_inst(id_inst)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_dropped(perf_dropped)
`endif
  );
  typedef struct {
    bit ir; bit rd; logic [31:0] rpc;
    bit rv; logic [31:0] addr; bit idv; logic [31:0] pc;
  } vec_t;
  vec_t tbl [10];
  int n_cmp, n_err, cyc, lat, last_due;
  logic [31:0] addr_q [$];
  int due_q [$];
  logic [31:0] req_log [$];
  logic [31:0] id_log [$];
  logic [31:0] m_req_pc, m_id_pc, s_addr, s_idpc;
  logic s_rv, s_idv;
  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic do_reset();
    rst = 1'b0;
    imem_req_ready = 1'b0; id_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    addr_q.delete(); due_q.delete(); last_due = -1;
    #1;
    chk("reset_req_valid", 32'(imem_req_valid), 0);
    chk("reset_id_valid", 32'(id_valid), 0);
    chk("reset_id_pc", id_pc, 0);
    chk("reset_id_inst", id_inst, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1; cyc = 0; m_req_pc = '0; m_id_pc = '0;
  endtask
  // one clock: drive inputs and any due imem response, sample at negedge, update the model
  task automatic step(input bit rr, input bit ir, input bit rd, input logic [31:0] rpc);
    int d;
    imem_req_ready = rr; id_ready = ir; redirect_valid = rd; redirect_pc = rpc;
    if (due_q.size() > 0 && due_q[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = inst_of(addr_q.pop_front());
      void'(due_q.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    @(negedge clk);
    s_rv = imem_req_valid; s_idv = id_valid; s_addr = imem_req_addr; s_idpc = id_pc;
    if (rd) begin
      chk("redir_req_valid", 32'(s_rv), 0);
      chk("redir_id_valid", 32'(s_idv), 0);
    end
    if (s_rv && rr) begin
      chk("req_addr", s_addr, m_req_pc);
      req_log.push_back(s_addr);
      addr_q.push_back(s_addr);
      d = cyc + lat;
      if (d <= last_due) d = last_due + 1;
      due_q.push_back(d);
      last_due = d;
      m_req_pc += 32'd4;
    end
    if (s_idv && ir) begin
      chk("id_pc", s_idpc, m_id_pc);
      chk("id_inst", id_inst, inst_of(m_id_pc));
      id_log.push_back(s_idpc);
      m_id_pc += 32'd4;
    end
    if (rd) begin
      m_req_pc = {rpc[31:2], 2'b00};
      m_id_pc  = m_req_pc;
    end
    chk("inflight_cap", 32'(addr_q.size() <= DEPTH), 1);
    @(posedge clk); #1;
    cyc++;
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end
  initial begin
    int r0, i0, k0;
    logic [31:0] rpc;
    n_cmp = 0; n_err = 0; lat = 1; cyc = 0;
    tbl[0] = '{1, 0, 32'h0,   1, 32'h00,  0, 32'h0};
    tbl[1] = '{1, 0, 32'h0,   1, 32'h04,  0, 32'h0};
    tbl[2] = '{1, 0, 32'h0,   1, 32'h08,  1, 32'h00};
    tbl[3] = '{1, 0, 32'h0,   1, 32'h0C,  1, 32'h04};
    tbl[4] = '{1, 0, 32'h0,   1, 32'h10,  1, 32'h08};
    tbl[5] = '{1, 0, 32'h0,   1, 32'h14,  1, 32'h0C};
    tbl[6] = '{1, 1, 32'h103, 0, 32'h0,   0, 32'h0};
    tbl[7] = '{1, 0, 32'h0,   1, 32'h100, 0, 32'h0};
    tbl[8] = '{1, 0, 32'h0,   1, 32'h104, 0, 32'h0};
    tbl[9] = '{1, 0, 32'h0,   1, 32'h108, 1, 32'h100};
    do_reset();
    lat = 1;
    for (int r = 0; r < 10; r++) begin
      step(1'b1, tbl[r].ir, tbl[r].rd, tbl[r].rpc);
      chk("tbl_req_valid", 32'(s_rv), 32'(tbl[r].rv));
      if (tbl[r].rv) chk("tbl_req_addr", s_addr, tbl[r].addr);
      chk("tbl_id_valid", 32'(s_idv), 32'(tbl[r].idv));
      if (tbl[r].idv) chk("tbl_id_pc", s_idpc, tbl[r].pc);
    end
    do_reset();
    lat = 1;
    r0 = req_log.size();
    repeat (10) step(1'b1, 1'b0, 1'b0, '0);
    chk("stall_req_count", 32'(req_log.size() - r0), 4);
    chk("stall_req_valid", 32'(s_rv), 0);
    k0 = id_log.size(); r0 = req_log.size();
    repeat (4) step(1'b1, 1'b1, 1'b0, '0);
    chk("drain_count", 32'(id_log.size() - k0), 4);
    chk("resume_addr", req_log.size() > r0 ? req_log[r0] : 32'hFFFF_FFFF, 32'h10);
    do_reset();
    lat = 3;
    step(1'b1, 1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 1'b0, '0);
    chk("inflight_at_redirect", 32'(addr_q.size()), 2);
    step(1'b1, 1'b1, 1'b1, 32'h100);
    r0 = req_log.size(); i0 = id_log.size();
    for (int t = 0; t < 20 && id_log.size() == i0; t++) step(1'b1, 1'b1, 1'b0, '0);
    chk("redir_first_req", req_log.size() > r0 ? req_log[r0] : 32'hFFFF_FFFF, 32'h100);
    chk("redir_first_id", id_log.size() > i0 ? id_log[i0] : 32'hFFFF_FFFF, 32'h100);
    step(1'b1, 1'b1, 1'b1, 32'h203);
    r0 = req_log.size();
    for (int t = 0; t < 20 && req_log.size() == r0; t++) step(1'b1, 1'b1, 1'b0, '0);
    chk("misaligned_redir_req", req_log.size() > r0 ? req_log[r0] : 32'hFFFF_FFFF, 32'h200);
    do_reset();
    lat = 2;
    repeat (4) step(1'b1, 1'b1, 1'b0, '0);
    k0 = id_log.size();
    step(1'b1, 1'b1, 1'b1, 32'h40);
    chk("redir_rsp_id_handshake", 32'(id_log.size() - k0), 0);
    chk("redir_rsp_drop_cnt", 32'(dut.drop_cnt_q), 32'(addr_q.size()));
    chk("redir_rsp_drop_val", 32'(dut.drop_cnt_q), 1);
    i0 = id_log.size();
    for (int t = 0; t < 20 && id_log.size() == i0; t++) step(1'b1, 1'b1, 1'b0, '0);
    chk("redir_rsp_first_id", id_log.size() > i0 ? id_log[i0] : 32'hFFFF_FFFF, 32'h40);
    do_reset();
    k0 = id_log.size();
    for (int t = 0; t < 4000; t++) begin
      if (t % 500 == 0) lat = $urandom_range(1, 5);
      rpc = $urandom;
      if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, rpc);
    end
    chk("random_progress", 32'(id_log.size() - k0 > 500), 1);
`ifdef FETCH_PERF_EN
    do_reset();
    lat = 1;
    chk("perf_fetched_reset", perf_fetched, 0);
    chk("perf_dropped_reset", perf_dropped, 0);
    repeat (4) step(1'b1, 1'b0, 1'b0, '0);
    repeat (2) step(1'b0, 1'b0, 1'b0, '0);
    repeat (3) step(1'b0, 1'b1, 1'b0, '0);
    repeat (3) step(1'b1, 1'b0, 1'b0, '0);
    repeat (2) step(1'b0, 1'b0, 1'b0, '0);
    repeat (2) step(1'b0, 1'b1, 1'b0, '0);
    step(1'b0, 1'b0, 1'b1, 32'h80);
    chk("perf_fetched", perf_fetched, 5);
    chk("perf_dropped", perf_dropped, 2);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
